// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the Mini SRC branch condition unit:
// condition-code values, FSM state encoding and code-class helpers.
package branch_cond_unit_pkg;

    localparam logic [3:0] COND_ZR  = 4'h0;
    localparam logic [3:0] COND_NZ  = 4'h1;
    localparam logic [3:0] COND_PL  = 4'h2;
    localparam logic [3:0] COND_MI  = 4'h3;
    localparam logic [3:0] COND_EQ  = 4'h4;
    localparam logic [3:0] COND_NE  = 4'h5;
    localparam logic [3:0] COND_LT  = 4'h6;
    localparam logic [3:0] COND_GE  = 4'h7;
    localparam logic [3:0] COND_LTU = 4'h8;
    localparam logic [3:0] COND_GEU = 4'h9;
    localparam logic [3:0] COND_ALW = 4'hA;
    localparam logic [3:0] COND_NEV = 4'hB;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    // Codes that look only at the bus value (ALW/NEV included).
    function automatic logic is_single_op_code(input logic [3:0] code);
        return (code <= COND_MI) || (code == COND_ALW) || (code == COND_NEV);
    endfunction

    function automatic logic is_two_op_code(input logic [3:0] code);
        return (code >= COND_EQ) && (code <= COND_GEU);
    endfunction

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition evaluator: decodes a 4-bit condition code against
// operands A and B and flags codes that do not fit the requested operand class.
module cond_eval
    import branch_cond_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_two_op,
    output logic             result,
    output logic             illegal
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    raw;

    assign a_s = op_a;
    assign b_s = op_b;

    always_comb begin
        raw = 1'b0;
        case (code)
            COND_ZR:  raw = (op_b == '0);
            COND_NZ:  raw = (op_b != '0);
            COND_PL:  raw = !op_b[WIDTH-1] && (op_b != '0);
            COND_MI:  raw = op_b[WIDTH-1];
            COND_EQ:  raw = (op_a == op_b);
            COND_NE:  raw = (op_a != op_b);
            COND_LT:  raw = (a_s < b_s);
            COND_GE:  raw = (a_s >= b_s);
            COND_LTU: raw = (op_a < op_b);
            COND_GEU: raw = (op_a >= op_b);
            COND_ALW: raw = 1'b1;
            default:  raw = 1'b0;
        endcase
    end

    assign illegal = is_two_op ? !is_two_op_code(code) : !is_single_op_code(code);
    // An illegal request always resolves to "not taken".
    assign result  = raw && !illegal;

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds captured operand A, the IDLE/ARMED compare FSM,
// the registered CON decision, its one-cycle valid pulse and a sticky error flag.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int C2_W  = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [WIDTH-1:0] BusMuxOut,
    input  logic [C2_W-1:0]  C2,
    input  logic             CONin,
    input  logic             Ain,
    input  logic             CMPin,
    output logic             CON,
    output logic             con_valid,
    output logic             armed,
    output logic             cond_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             con_q, con_d;
    logic             con_valid_q, con_valid_d;
    logic             cond_err_q, cond_err_d;

    logic             eval_result;
    logic             eval_illegal;
    logic             collision;
    logic [3:0]       code;

    assign code = C2[3:0];

    // CMPin has top priority, so the evaluator runs in two-operand mode whenever it is set.
    cond_eval #(
        .WIDTH(WIDTH)
    ) u_cond_eval (
        .code      (code),
        .op_a      (a_q),
        .op_b      (BusMuxOut),
        .is_two_op (CMPin),
        .result    (eval_result),
        .illegal   (eval_illegal)
    );

    assign collision = (CMPin && CONin) || (CMPin && Ain) || (CONin && Ain);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        con_d       = con_q;
        con_valid_d = 1'b0;
        cond_err_d  = cond_err_q;

        if (collision) begin
            cond_err_d = 1'b1;
        end

        if (CMPin) begin
            con_valid_d = 1'b1;
            state_d     = ST_IDLE;
            if ((state_q == ST_ARMED) && !eval_illegal) begin
                con_d = eval_result;
            end else begin
                con_d      = 1'b0;
                cond_err_d = 1'b1;
            end
        end else if (CONin) begin
            con_valid_d = 1'b1;
            if (!eval_illegal) begin
                con_d = eval_result;
            end else begin
                con_d      = 1'b0;
                cond_err_d = 1'b1;
            end
        end else if (Ain) begin
            state_d = ST_ARMED;
            a_d     = BusMuxOut;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            con_q       <= 1'b0;
            con_valid_q <= 1'b0;
            cond_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            con_q       <= con_d;
            con_valid_q <= con_valid_d;
            cond_err_q  <= cond_err_d;
        end
    end

    assign CON       = con_q;
    assign con_valid = con_valid_q;
    assign armed     = (state_q == ST_ARMED);
    assign cond_err  = cond_err_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed scenarios followed by
// randomized strobes, all checked against a behavioural model of the unit.
module tb_branch_cond_unit;

    localparam int WIDTH = 32;
    localparam int C2_W  = 6;

    logic             Clock;
    logic             Clear;
    logic [WIDTH-1:0] BusMuxOut;
    logic [C2_W-1:0]  C2;
    logic             CONin;
    logic             Ain;
    logic             CMPin;
    logic             CON;
    logic             con_valid;
    logic             armed;
    logic             cond_err;

    int n_cmp;
    int n_bad;

    // Behavioural model state
    bit          m_armed;
    logic [31:0] m_a;
    bit          m_con;
    bit          m_vld;
    bit          m_err;

    branch_cond_unit #(
        .WIDTH (WIDTH),
        .C2_W  (C2_W)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .BusMuxOut (BusMuxOut),
        .C2        (C2),
        .CONin     (CONin),
        .Ain       (Ain),
        .CMPin     (CMPin),
        .CON       (CON),
        .con_valid (con_valid),
        .armed     (armed),
        .cond_err  (cond_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic bit ref_cond(input int code, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        case (code)
            0:  return sb == 0;
            1:  return sb != 0;
            2:  return sb > 0;
            3:  return sb < 0;
            4:  return sa == sb;
            5:  return sa != sb;
            6:  return sa < sb;
            7:  return sa >= sb;
            8:  return ua < ub;
            9:  return ua >= ub;
            10: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_single(input int code);
        return (code <= 3) || (code == 10) || (code == 11);
    endfunction

    function automatic bit ref_two(input int code);
        return (code >= 4) && (code <= 9);
    endfunction

    task automatic model_reset();
        m_armed = 0;
        m_a     = '0;
        m_con   = 0;
        m_vld   = 0;
        m_err   = 0;
    endtask

    task automatic model_step(input bit cmp, input bit cn, input bit ain,
                              input int code, input logic [31:0] b);
        int n;
        n     = int'(cmp) + int'(cn) + int'(ain);
        m_vld = 0;
        if (n > 1) m_err = 1;
        if (cmp) begin
            m_vld = 1;
            if (m_armed && ref_two(code)) begin
                m_con = ref_cond(code, m_a, b);
            end else begin
                m_con = 0;
                m_err = 1;
            end
            m_armed = 0;
        end else if (cn) begin
            m_vld = 1;
            if (ref_single(code)) begin
                m_con = ref_cond(code, 32'd0, b);
            end else begin
                m_con = 0;
                m_err = 1;
            end
        end else if (ain) begin
            m_armed = 1;
            m_a     = b;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".CON"},       CON,       m_con);
        check({tag, ".con_valid"}, con_valid, m_vld);
        check({tag, ".armed"},     armed,     m_armed);
        check({tag, ".cond_err"},  cond_err,  m_err);
    endtask

    task automatic step(input string tag, input bit cmp, input bit cn, input bit ain,
                        input logic [C2_W-1:0] c2, input logic [31:0] bus);
        CMPin     = cmp;
        CONin     = cn;
        Ain       = ain;
        C2        = c2;
        BusMuxOut = bus;
        @(posedge Clock);
        #1;
        model_step(cmp, cn, ain, int'(c2[3:0]), bus);
        check_model(tag);
        CMPin = 0;
        CONin = 0;
        Ain   = 0;
    endtask

    task automatic pulse_reset(input string tag);
        Clear = 1'b0;
        @(posedge Clock);
        #1;
        model_reset();
        check_model(tag);
        Clear = 1'b1;
    endtask

    initial begin
        logic [31:0] bus;
        logic [C2_W-1:0] c2;
        bit cmp;
        bit cn;
        bit ain;

        n_cmp = 0;
        n_bad = 0;
        model_reset();
        Clear     = 1'b0;
        CMPin     = 0;
        CONin     = 0;
        Ain       = 0;
        C2        = '0;
        BusMuxOut = '0;

        // Reset held while strobes toggle
        for (int i = 0; i < 4; i++) begin
            CMPin     = i[0];
            CONin     = i[1];
            Ain       = 1'b1;
            C2        = C2_W'(i + 4);
            BusMuxOut = 32'hFFFF_FFFF;
            @(posedge Clock);
            #1;
            check("reset.CON",       CON,       1'b0);
            check("reset.con_valid", con_valid, 1'b0);
            check("reset.armed",     armed,     1'b0);
            check("reset.cond_err",  cond_err,  1'b0);
        end
        CMPin = 0;
        CONin = 0;
        Ain   = 0;
        Clear = 1'b1;

        // Single-operand tests
        step("pl_pos", 0, 1, 0, 6'd2, 32'h0000_0005);
        check("pl_pos.direct", CON, 1'b1);
        step("idle1", 0, 0, 0, 6'd2, 32'h0000_0005);
        check("idle1.vld_drop", con_valid, 1'b0);
        check("idle1.con_hold", CON, 1'b1);
        step("mi_neg", 0, 1, 0, 6'd3, 32'h8000_0000);
        check("mi_neg.direct", CON, 1'b1);
        step("pl_zero", 0, 1, 0, 6'd2, 32'h0000_0000);
        check("pl_zero.direct", CON, 1'b0);
        step("zr_upper", 0, 1, 0, 6'h30, 32'h0000_0000);
        check("zr_upper.direct", CON, 1'b1);

        // Signed vs unsigned compare
        step("lt_cap", 0, 0, 1, 6'd0, 32'hFFFF_FFFF);
        check("lt_cap.armed", armed, 1'b1);
        step("lt_cmp", 1, 0, 0, 6'd6, 32'h0000_0001);
        check("lt_cmp.direct", CON, 1'b1);
        check("lt_cmp.disarm", armed, 1'b0);
        step("ltu_cap", 0, 0, 1, 6'd0, 32'hFFFF_FFFF);
        step("ltu_cmp", 1, 0, 0, 6'd8, 32'h0000_0001);
        check("ltu_cmp.direct", CON, 1'b0);
        check("ltu_cmp.err_clean", cond_err, 1'b0);

        // Misuse
        step("cmp_idle", 1, 0, 0, 6'd4, 32'h0000_0000);
        check("cmp_idle.err", cond_err, 1'b1);
        check("cmp_idle.vld", con_valid, 1'b1);
        step("conin_two", 0, 1, 0, 6'd4, 32'h0000_0000);
        check("conin_two.con", CON, 1'b0);
        check("conin_two.err", cond_err, 1'b1);

        // Collision: compare uses the old A
        pulse_reset("rst_a");
        step("col_cap", 0, 0, 1, 6'd0, 32'h0000_0007);
        step("col_cmp", 1, 0, 1, 6'd4, 32'h0000_0007);
        check("col_cmp.con", CON, 1'b1);
        check("col_cmp.armed", armed, 1'b0);
        check("col_cmp.err", cond_err, 1'b1);

        // Reset while armed discards the pending compare
        pulse_reset("rst_b");
        step("mid_cap", 0, 0, 1, 6'd0, 32'h0000_0003);
        pulse_reset("rst_mid");
        step("mid_cmp", 1, 0, 0, 6'd4, 32'h0000_0003);
        check("mid_cmp.con", CON, 1'b0);
        check("mid_cmp.err", cond_err, 1'b1);

        // Randomized traffic
        pulse_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: bus = 32'h0;
                1: bus = 32'h8000_0000;
                2: bus = 32'hFFFF_FFFF;
                3: bus = m_a;
                4: bus = $urandom_range(0, 8);
                default: bus = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) c2 = C2_W'($urandom);
            else c2 = {C2_W'($urandom) >> 4, 4'($urandom_range(0, 11))};
            cmp = ($urandom_range(0, 9) < 3);
            cn  = ($urandom_range(0, 9) < 3);
            ain = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
            step("rand", cmp, cn, ain, c2, bus);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
